// File: rtl/fetch_unit.sv
// fetch_unit: program counter and IF/ID pipeline register for the 16-bit CPU.
// It drives the instruction-memory address and captures the returned fields
// into IF/ID. It also handles stall, redirect, end-of-memory halt and
// bad-target errors.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stall                 freeze PC and IF/ID
//   redirect_valid/target take a branch or jump to target
//   op, rs, rt, rd, imm   instruction fields for iaddr (combinational memory)
//   iaddr                 instruction address (PC register)
//   ins_mem_rw            memory read select, tied to read (0)
//   id_valid, id_pc, id_pc_plus2, id_op..id_imm   IF/ID register
//   halted, err           HALT state flag, sticky bad-redirect flag
//   fetch_count           saturating count of captured instructions
module fetch_unit #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic [3:0]        op,
  input  logic [3:0]        rs,
  input  logic [3:0]        rt,
  input  logic [3:0]        rd,
  input  logic [3:0]        imm,
  output logic [ADDR_W-1:0] iaddr,
  output logic              ins_mem_rw,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus2,
  output logic [3:0]        id_op,
  output logic [3:0]        id_rs,
  output logic [3:0]        id_rt,
  output logic [3:0]        id_rd,
  output logic [3:0]        id_imm,
  output logic              halted,
  output logic              err,
  output logic [15:0]       fetch_count
);

  localparam int unsigned FIELD_W = 4;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic                 id_valid_q, id_valid_d;
  logic [ADDR_W-1:0]    id_pc_q, id_pc_d;
  logic [ADDR_W-1:0]    id_pc2_q, id_pc2_d;
  logic [FIELD_W-1:0]   id_op_q, id_op_d, id_rs_q, id_rs_d, id_rt_q, id_rt_d;
  logic [FIELD_W-1:0]   id_rd_q, id_rd_d, id_imm_q, id_imm_d;
  logic                 halted_q, halted_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [ADDR_W-1:0]    pc_plus2_c;
  logic                 bad_target_c;
  logic                 pc_last_c;

  // Address arithmetic and target checks; comparisons are widened to 32 bits
  // so MEM_BYTES never has to fit in ADDR_W.
  always_comb begin
    pc_plus2_c   = pc_q + ADDR_W'(2);
    bad_target_c = redirect_target[0] | (32'(redirect_target) >= MEM_BYTES);
    pc_last_c    = (32'(pc_plus2_c) >= MEM_BYTES);
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_pc2_d   = id_pc2_q;
    id_op_d    = id_op_q;
    id_rs_d    = id_rs_q;
    id_rt_d    = id_rt_q;
    id_rd_d    = id_rd_q;
    id_imm_d   = id_imm_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect_valid && bad_target_c) begin
          err_d      = 1'b1;
          state_d    = HALT;
          id_valid_d = 1'b0;
        end else if (redirect_valid) begin
          pc_d       = redirect_target;
          id_valid_d = 1'b0;
        end else if (!stall) begin
          id_valid_d = 1'b1;
          id_pc_d    = pc_q;
          id_pc2_d   = pc_plus2_c;
          id_op_d    = op;
          id_rs_d    = rs;
          id_rt_d    = rt;
          id_rd_d    = rd;
          id_imm_d   = imm;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          // The last word is still delivered; the PC parks on it.
          if (pc_last_c) state_d = HALT;
          else           pc_d    = pc_plus2_c;
        end
      end
      HALT: begin
        if (redirect_valid && !err_q && !bad_target_c) begin
          pc_d       = redirect_target;
          state_d    = RUN;
          id_valid_d = 1'b0;
        end else if (redirect_valid && !err_q) begin
          err_d      = 1'b1;
          id_valid_d = 1'b0;
        end else if (!stall) begin
          id_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    halted_d = (state_d == HALT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= ADDR_W'(RESET_PC);
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_pc2_q   <= '0;
      id_op_q    <= '0;
      id_rs_q    <= '0;
      id_rt_q    <= '0;
      id_rd_q    <= '0;
      id_imm_q   <= '0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_pc2_q   <= id_pc2_d;
      id_op_q    <= id_op_d;
      id_rs_q    <= id_rs_d;
      id_rt_q    <= id_rt_d;
      id_rd_q    <= id_rd_d;
      id_imm_q   <= id_imm_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign iaddr       = pc_q;
  assign ins_mem_rw  = 1'b0;
  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus2 = id_pc2_q;
  assign id_op       = id_op_q;
  assign id_rs       = id_rs_q;
  assign id_rt       = id_rt_q;
  assign id_rd       = id_rd_q;
  assign id_imm      = id_imm_q;
  assign halted      = halted_q;
  assign err         = err_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized
// stall/redirect/reset traffic, all compared against a behavioural model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [3:0]  op, rs, rt, rd, imm;
  logic [15:0] iaddr;
  logic        ins_mem_rw;
  logic        id_valid;
  logic [15:0] id_pc, id_pc_plus2;
  logic [3:0]  id_op, id_rs, id_rt, id_rd, id_imm;
  logic        halted, err;
  logic [15:0] fetch_count;

  fetch_unit #(.ADDR_W(16), .MEM_BYTES(64), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .iaddr(iaddr), .ins_mem_rw(ins_mem_rw),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus2(id_pc_plus2),
    .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .halted(halted), .err(err), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: 32 words of {op, rs, rt, rd, imm}, read combinationally.
  logic [19:0] mem [32];
  logic [19:0] rd_word;
  always_comb begin
    rd_word = 20'd0;
    if (iaddr < 16'd64) rd_word = mem[iaddr[5:1]];
    op  = rd_word[19:16];
    rs  = rd_word[15:12];
    rt  = rd_word[11:8];
    rd  = rd_word[7:4];
    imm = rd_word[3:0];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: current architectural view of the fetch stage.
  bit          m_boot, m_halted, m_err, m_idv;
  int          m_pc;
  int          m_id_pc, m_id_pc2;
  logic [19:0] m_word;
  int          m_cnt;

  task automatic model_reset();
    m_boot = 1; m_halted = 0; m_err = 0; m_idv = 0;
    m_pc = 0; m_id_pc = 0; m_id_pc2 = 0; m_word = 20'd0; m_cnt = 0;
  endtask

  task automatic model_step(input bit st, input bit rv, input int tgt);
    bit bad;
    bad = (tgt % 2 == 1) || (tgt >= 64);
    if (m_boot) begin
      m_boot = 0;
    end else if (!m_halted) begin
      if (rv && bad) begin
        m_err = 1; m_halted = 1; m_idv = 0;
      end else if (rv) begin
        m_pc = tgt; m_idv = 0;
      end else if (!st) begin
        m_idv    = 1;
        m_id_pc  = m_pc;
        m_id_pc2 = (m_pc + 2) % 65536;
        m_word   = mem[m_pc / 2];
        m_cnt    = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        if (m_pc + 2 < 64) m_pc = m_pc + 2;
        else               m_halted = 1;
      end
    end else begin
      if (rv && !m_err && !bad) begin
        m_pc = tgt; m_halted = 0; m_idv = 0;
      end else if (!st) begin
        m_idv = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".iaddr"},   32'(iaddr),       32'(m_pc));
    check({tag, ".rw"},      32'(ins_mem_rw),  32'd0);
    check({tag, ".valid"},   32'(id_valid),    32'(m_idv));
    check({tag, ".id_pc"},   32'(id_pc),       32'(m_id_pc));
    check({tag, ".id_pc2"},  32'(id_pc_plus2), 32'(m_id_pc2));
    check({tag, ".fields"},  {12'd0, id_op, id_rs, id_rt, id_rd, id_imm}, {12'd0, m_word});
    check({tag, ".halted"},  32'(halted),      32'(m_halted));
    check({tag, ".err"},     32'(err),         32'(m_err));
    check({tag, ".count"},   32'(fetch_count), 32'(m_cnt));
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input string tag, input bit st, input bit rv, input logic [15:0] tgt);
    stall           = st;
    redirect_valid  = rv;
    redirect_target = tgt;
    model_step(st, rv, int'(tgt));
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge; release on a negedge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = 16'd0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all({tag, ".boot"});
  endtask

  initial begin
    int stuck;
    rst_n = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = 16'd0;
    for (int i = 0; i < 32; i++) mem[i] = 20'($urandom);
    mem[0] = 20'h81234;  // add
    mem[1] = 20'h9a5b6;  // sub
    mem[2] = 20'ha7c8d;  // or
    model_reset();

    // Reset start: iaddr 0,0,2,4 and first capture in cycle 3.
    do_reset("reset");
    check("start.iaddr0", 32'(iaddr), 32'd0);
    cycle("start1", 0, 0, 16'd0);
    check("start.iaddr1", 32'(iaddr), 32'd0);
    check("start.valid1", 32'(id_valid), 32'd0);
    cycle("start2", 0, 0, 16'd0);
    check("start.iaddr2", 32'(iaddr), 32'd2);
    check("start.valid2", 32'(id_valid), 32'd1);
    check("start.id_pc", 32'(id_pc), 32'd0);
    check("start.id_pc2", 32'(id_pc_plus2), 32'd2);
    check("start.op", 32'(id_op), 32'h8);
    check("start.count", 32'(fetch_count), 32'd1);
    cycle("start3", 0, 0, 16'd0);
    check("start.iaddr3", 32'(iaddr), 32'd4);

    // Stall for 3 cycles at PC=4.
    for (int i = 0; i < 3; i++) cycle("stall", 1, 0, 16'd0);
    check("stall.iaddr", 32'(iaddr), 32'd4);
    check("stall.id_pc", 32'(id_pc), 32'd2);
    check("stall.valid", 32'(id_valid), 32'd1);
    check("stall.count", 32'(fetch_count), 32'd2);
    cycle("unstall", 0, 0, 16'd0);
    check("unstall.id_pc", 32'(id_pc), 32'd4);

    // Redirect outranks stall at PC=6.
    check("redir.pc6", 32'(iaddr), 32'd6);
    cycle("redir", 1, 1, 16'h0010);
    check("redir.iaddr", 32'(iaddr), 32'h10);
    check("redir.valid", 32'(id_valid), 32'd0);
    cycle("redir2", 0, 0, 16'd0);
    check("redir2.id_pc", 32'(id_pc), 32'h10);
    check("redir2.valid", 32'(id_valid), 32'd1);

    // End of memory: deliver 56..62, then halt with PC parked at 62.
    cycle("eom.jump", 0, 1, 16'd56);
    for (int a = 56; a <= 62; a += 2) begin
      cycle("eom.run", 0, 0, 16'd0);
      check("eom.id_pc", 32'(id_pc), 32'(a));
    end
    check("eom.halted", 32'(halted), 32'd1);
    check("eom.iaddr", 32'(iaddr), 32'd62);
    cycle("eom.idle", 0, 0, 16'd0);
    check("eom.valid", 32'(id_valid), 32'd0);
    check("eom.iaddr2", 32'(iaddr), 32'd62);
    cycle("eom.resume", 0, 1, 16'd0);
    check("eom.resume.halted", 32'(halted), 32'd0);
    check("eom.resume.iaddr", 32'(iaddr), 32'd0);
    cycle("eom.after", 0, 0, 16'd0);

    // Bad redirects: odd target, then out-of-range target after a reset.
    cycle("bad.odd", 0, 1, 16'h0005);
    check("bad.err", 32'(err), 32'd1);
    check("bad.halted", 32'(halted), 32'd1);
    check("bad.valid", 32'(id_valid), 32'd0);
    cycle("bad.ignored", 0, 1, 16'h0002);
    check("bad.ignored.halted", 32'(halted), 32'd1);
    check("bad.ignored.err", 32'(err), 32'd1);
    do_reset("reset2");
    cycle("r2a", 0, 0, 16'd0);
    cycle("r2b", 0, 0, 16'd0);
    cycle("bad.range", 0, 1, 16'h0040);
    check("bad.range.err", 32'(err), 32'd1);
    check("bad.range.halted", 32'(halted), 32'd1);
    cycle("bad.range.ignored", 0, 1, 16'h0002);
    check("bad.range.ignored.iaddr", 32'(iaddr), 32'd2);

    // Async reset mid-cycle at PC=0x20 with a valid instruction in IF/ID.
    do_reset("reset3");
    cycle("r3a", 0, 0, 16'd0);
    cycle("r3jump", 0, 1, 16'h001c);
    cycle("r3b", 0, 0, 16'd0);
    cycle("r3c", 0, 0, 16'd0);
    check("mid.pc", 32'(iaddr), 32'h20);
    check("mid.valid", 32'(id_valid), 32'd1);
    #2;
    do_reset("midreset");
    check("midreset.iaddr", 32'(iaddr), 32'd0);
    cycle("mr1", 0, 0, 16'd0);
    cycle("mr2", 0, 0, 16'd0);
    check("midreset.first", 32'(id_pc), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 32; i++) mem[i] = 20'($urandom);
    stuck = 0;
    for (int n = 0; n < 600; n++) begin
      bit st, rv;
      logic [15:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 9) == 0) || (m_halted && !m_err && $urandom_range(0, 3) == 0);
      tgt = 16'(2 * $urandom_range(0, 31));
      if (rv && (!m_halted || m_err) && $urandom_range(0, 5) == 0)
        tgt = 16'($urandom) | 16'd1;
      else if (rv && (!m_halted || m_err) && $urandom_range(0, 7) == 0)
        tgt = 16'($urandom_range(64, 65534)) & 16'hfffe;
      cycle("rand", st, rv, tgt);
      stuck = m_err ? stuck + 1 : 0;
      if ($urandom_range(0, 99) == 0 || stuck > 20) begin
        #2;
        do_reset("rand.reset");
        stuck = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and IF/ID stage for the 16-bit CPU. It drives the instruction-memory address and holds the memory's read select at read. It captures the decoded op/rs/rt/rd/imm fields into an IF/ID register for the control unit and register file. It also handles stall, redirect from jal/jalr/beq/ble, end-of-memory halt and bad-target errors.

## Interface
Parameters:
- `ADDR_W`, 16 — PC and address width.
- `MEM_BYTES`, 64 — instruction-memory size in bytes. Must be even.
- `RESET_PC`, 0 — PC after reset. Must be even and below `MEM_BYTES`.

Ports:
- `clk` in 1 — the only clock. All state changes on its rising edge.
- `rst_n` in 1 — reset, asynchronous assert, active-low.
- `stall` in 1 — hold the PC and the IF/ID register.
- `redirect_valid` in 1 — take a branch or jump.
- `redirect_target` in `ADDR_W` — new PC.
- `op`, `rs`, `rt`, `rd`, `imm` in 4 each — fields returned by instruction memory for `iaddr`.
- `iaddr` out `ADDR_W` — instruction address, equal to the PC register.
- `ins_mem_rw` out 1 — constant 0 (read).
- `id_valid` out 1 — IF/ID holds a real instruction.
- `id_pc` out `ADDR_W` — address of the captured instruction.
- `id_pc_plus2` out `ADDR_W` — `id_pc`+2, the jal/jalr link value.
- `id_op`, `id_rs`, `id_rt`, `id_rd`, `id_imm` out 4 each — captured fields.
- `halted` out 1 — high in HALT.
- `err` out 1 — sticky bad-redirect flag.
- `fetch_count` out 16 — number of captured instructions, saturating.

## Operation
- **States:** BOOT, RUN, HALT (2-bit encoding).
  - BOOT lasts exactly one cycle after reset release. PC holds, `id_valid`=0, then the state moves to RUN.
- **RUN, per cycle, in priority order:**
  1. Redirect with a bad target (`redirect_target[0]`=1 or `redirect_target` ≥ `MEM_BYTES`): `err`<=1, state<=HALT, PC holds, `id_valid`<=0.
  2. Redirect with a good target: PC<=`redirect_target`, `id_valid`<=0 (flush). No capture.
  3. `stall`: PC and all `id_*` hold, including `id_valid`.
  4. Otherwise capture: `id_*`<=fields, `id_pc`<=PC, `id_pc_plus2`<=PC+2, `id_valid`<=1, `fetch_count`++.
     - If PC+2 < `MEM_BYTES`, PC<=PC+2.
     - Else PC holds and state<=HALT (the last instruction is still delivered).
- **HALT:**
  - No capture, PC holds.
  - `id_valid`<=0 on every non-stall cycle; it holds while `stall`=1.
  - A good redirect while `err`=0 sets PC<=target and state<=RUN, with `id_valid`<=0.
  - Redirects are ignored while `err`=1.
- **Arithmetic:** PC+2 is computed at `ADDR_W` bits. `fetch_count` stops at 0xFFFF.
- **Simultaneous events:** redirect outranks stall. The fields presented while a redirect is taken are discarded.
- **Reset (asynchronous, at any point including mid-operation):**
  - PC=`RESET_PC`, state=BOOT.
  - `id_valid`=0, all `id_*`=0, `id_pc_plus2`=0.
  - `halted`=0, `err`=0, `fetch_count`=0.
  - `ins_mem_rw`=0 always.

## Timing
- `iaddr` is a register output. Instruction memory is combinational, so the fields for `iaddr` are valid in the same cycle.
- Fetch-to-IF/ID latency is 1 cycle: an instruction at address A in cycle n appears on `id_*` in cycle n+1.
- First instruction after reset release: BOOT cycle, then `iaddr`=`RESET_PC` in the RUN cycle, then `id_valid`=1 one cycle later.
- Redirect penalty is 1 bubble. The target's instruction reaches IF/ID 2 cycles after the redirect cycle.
- `halted` and `err` are registered and rise in the cycle after the triggering edge.
- Stall has no latency: it freezes the state on the same edge.

## Test plan
- **Reset start:** release `rst_n`, mem[0..5] = add/sub/or. Required:
  - `iaddr` = 0, 0, 2, 4 over four cycles.
  - `id_valid` rises in cycle 3 with `id_pc`=0, `id_pc_plus2`=2, `id_op`=4'b1000.
  - `fetch_count`=1.
- **Stall:** assert `stall` for 3 cycles at PC=4 → `iaddr` stays at 4, `id_pc` stays at 2, `id_valid` stays at 1, `fetch_count` unchanged. After release, `id_pc`=4.
- **Redirect over stall:** at PC=6, `redirect_valid`=1, target=0x0010, `stall`=1. Required:
  - Next cycle: `iaddr`=0x10, `id_valid`=0.
  - The cycle after: `id_pc`=0x10, `id_valid`=1.
- **End of memory (`MEM_BYTES`=64):** run from 56 → `id_pc` 56..62 are delivered, `halted`=1 after the 62 capture, `iaddr` holds at 62, `id_valid`=0 the following cycle. A redirect to 0 then resumes with `halted`=0.
- **Bad redirect:** target=0x0005 → `err`=1, `halted`=1, `id_valid`=0. A later redirect to 0x0002 is ignored. The same test with target=0x0040 gives the same result.
- **Async reset mid-run:** drop `rst_n` mid-cycle at PC=0x20 with `id_valid`=1 → all outputs reach reset values immediately, without waiting for a clock edge. After release, the BOOT sequence restarts at `RESET_PC`.
